bcd_to_binary_seq: RTL
======================

// Module: bcd_to_binary_seq
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double-dabble): the inverse of the display-path binary-to-BCD encoder.
//  Converts DIGITS packed BCD digits from SW/digit-entry logic (e.g. a player-entered target or best time, 0000-9999)
//  into a BIN_W-bit binary value for compare against the race timer. One result bit per clock.
//  Start/busy/done handshake.
// PARAMETERS
//  DIGITS  4   number of BCD digits in bcd_in
//  BIN_W   14  binary result width; must satisfy 2**BIN_W > 10**DIGITS-1; also the iteration count
// PORTS
//  clk_in   in   1           system clock, rising-edge
//  rst      in   1           asynchronous, active-high reset
//  start    in   1           conversion request; sampled only in IDLE or DONE
//  bcd_in   in   4*DIGITS    packed BCD, digit 0 (units) in [3:0]; sampled on accepted start
//  busy     out  1           high while converting (LOAD/SHIFT)
//  done     out  1           one-cycle pulse: bin_out/err valid
//  bin_out  out  BIN_W       converted value; held until next accepted start
//  err      out  1           invalid-digit flag (BCD_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, bin_out=0, err=0, iteration counter=0, shift reg=0; effective immediately (async).
//  Datapath: shift reg {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]}, width 4*DIGITS+BIN_W.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : start=1 -> load bcd=bcd_in, bin=0, cnt=0, busy=1, go SHIFT. start=0 -> stay.
//   SHIFT: each clock: logical right-shift whole reg by 1; then every BCD nibble >=8 gets -3
//          (nibble correction applied to post-shift value, same cycle). cnt++.
//          After BIN_W shifts: bin_out<=bin, done<=1, busy<=0, go DONE.
//   DONE : done high exactly this one cycle. start=1 -> accept as in IDLE (back-to-back allowed), else go IDLE.
//  Latency: start sampled at edge N -> done high after edge N+BIN_W+1 (15 clocks for BIN_W=14); throughput 1 per BIN_W+1.
//  start while busy=1: ignored, no queuing, no effect on current conversion or bcd latch.
//  bcd_in changes during SHIFT: no effect (latched at accept).
//  rst mid-conversion: abort, all outputs to reset values, no done pulse.
//  Arithmetic: nibble correction modulo 16 in 4 bits; no carries between nibbles; bin_out exact for valid BCD
//  (max 9999 -> 14'h270F). bin_out updates only on the done cycle.
// CONFIGURATION
//  BCD_CHECK_EN defined: at accept, any digit >9 -> skip SHIFT, go DONE next clock: done=1, err=1, bin_out=0.
//   err held until next accepted start (cleared on accept).
//  BCD_CHECK_EN undefined: no check, err tied 0; digits >9 converted mechanically (deterministic, meaningless result).
// STRUCTURE
//  Shared package drag_pkg: DIGITS/BIN_W defaults, BCD_MAX=9999, state enum {IDLE,SHIFT,DONE}.
//  Same package the binary-to-BCD encoder and the timer use.
//  Sub-module bcd_nibble_corr: 4-bit in/out, out = (in>=8) ? in-3 : in; instantiated DIGITS times via generate.
//  Counter width $clog2(BIN_W+1).
// TESTING
//  1. bcd_in=16'h0000, start pulse -> done after 15 clocks, bin_out=0, err=0; busy high 14 clocks.
//  2. bcd_in=16'h9999 -> bin_out=14'd9999; bcd_in=16'h0200 -> 200; bcd_in=16'h0045 -> 45.
//  3. start=1 every cycle with bcd_in changing each clock from 16'h1234 -> first done gives 1234;
//     next accepted in DONE cycle, done pulses every 15 clocks.
//  4. start re-pulsed at clock 5 of conversion with bcd_in=16'h7777 -> ignored; result of original value only.
//  5. rst asserted at clock 7 of conversion of 16'h5000 -> busy/done/bin_out=0 same cycle;
//     next conversion of 16'h0001 -> 1.
//  6. BCD_CHECK_EN: bcd_in=16'h00A0 -> done 2 clocks after start, err=1, bin_out=0;
//     then 16'h0010 -> err=0, bin_out=10.

Source files
------------

// File: rtl/drag_pkg.sv
// drag_pkg: shared sizing and state encoding for the timer, the BCD encoder and the BCD-to-binary converter.
package drag_pkg;
    localparam int DEF_DIGITS = 4;
    localparam int DEF_BIN_W  = 14;
    localparam int BCD_MAX    = 9999;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_to_binary_seq_nibble_corr.sv
// bcd_nibble_corr: reverse double-dabble digit fix-up, a halved tens carry arrives as 8 and must become 5.
module bcd_nibble_corr (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd8) ? nib_i - 4'd3 : nib_i;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential BCD-to-binary converter, one result bit per clock, start/busy/done handshake.
// Define BCD_CHECK_EN to reject non-decimal digits with err instead of converting them.
module bcd_to_binary_seq
    import drag_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);
    localparam int SW = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    state_t              state_q, state_d;
    logic [SW-1:0]       sr_q, sr_d, sh;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d, bad_q, bad_d, bad_in;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] corr;
    logic                accept, last;

    assign sh     = sr_q >> 1;
    assign accept = start && (state_q != SHIFT);
    assign last   = cnt_q == CW'(BIN_W - 1);

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_corr u_corr (.nib_i(sh[BIN_W+4*g +: 4]), .nib_o(corr[4*g +: 4]));
    end

`ifdef BCD_CHECK_EN
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_in[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
`else
    assign bad_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
        bad_d   = bad_q;
        if (accept) begin
            sr_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            bad_d   = bad_in;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            if (bad_q) begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = 1'b1;
                bin_d   = '0;
            end else begin
                // Last shift and result capture share one edge so the next start can be taken in DONE.
                sr_d  = {corr, sh[BIN_W-1:0]};
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    bin_d   = sh[BIN_W-1:0];
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign err     = err_q;
endmodule
